// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor providing a free-running 64-bit mtime and
// per-hart timer/software interrupts, with its registers behind a two-state bus slave.
module clint_timer #(
    parameter int          NUM_HARTS = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    input  logic                 ren,
    input  logic                 wen,
    input  logic [3:0]           byte_en,
    output logic [31:0]          rdata,
    output logic                 busy,
    output logic                 error,
    output logic [63:0]          mtime,
    output logic [NUM_HARTS-1:0] timer_int,
    output logic [NUM_HARTS-1:0] soft_int
);
    localparam int IW = NUM_HARTS > 1 ? $clog2(NUM_HARTS) : 1;
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    typedef enum logic {IDLE, RESP} state_t;
    typedef enum logic [1:0] {K_MSIP, K_CMP, K_TIME} kind_t;
    state_t state;
    kind_t kind_q, kind_d;
    logic [PW-1:0] pcnt;
    logic [63:0] mtimecmp [NUM_HARTS];
    logic [NUM_HARTS-1:0] msip;
    logic op_wr, err_q, hi_q;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0] wdata_q, off, rd_d;
    logic [3:0] be_q;
    logic [12:0] cmp_field;
    logic is_msip, is_cmp, is_time, dec_err, tick, wr_go;
    logic [63:0] mtime_nxt;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] b);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i] ? w[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    // Window offset is computed by subtraction so anything below the base also faults.
    assign off       = addr - BASE_ADDR;
    assign cmp_field = off[15:3] - 13'h0800;
    assign is_msip   = off[15:14] == 2'b00 && {20'd0, off[13:2]} < NUM_HARTS;
    assign is_cmp    = off[15:14] != 2'b00 && off[15:0] < 16'hBFF8 && {19'd0, cmp_field} < NUM_HARTS;
    assign is_time   = off[15:3] == 13'h17FF;
    assign dec_err   = off[31:16] != 16'h0 || off[1:0] != 2'b00 || (ren && wen) || !(is_msip || is_cmp || is_time);
    assign kind_d    = is_msip ? K_MSIP : is_cmp ? K_CMP : K_TIME;
    assign idx_d     = is_msip ? off[IW+1:2] : cmp_field[IW-1:0];
    assign tick      = pcnt == PW'(PRESCALE - 1);
    assign wr_go     = state == RESP && op_wr && !err_q;
    assign soft_int  = msip;

    // A bus write to either mtime half wins over the tick, with no carry across halves.
    always_comb begin
        mtime_nxt = tick ? mtime + 64'd1 : mtime;
        if (wr_go && kind_q == K_TIME)
            mtime_nxt = hi_q ? {merge(mtime[63:32], wdata_q, be_q), mtime[31:0]}
                             : {mtime[63:32], merge(mtime[31:0], wdata_q, be_q)};
    end

    // mtime reads sample the value that will be visible during the RESP cycle.
    assign rd_d = kind_d == K_MSIP ? {31'd0, msip[idx_d]} :
                  kind_d == K_CMP  ? (off[2] ? mtimecmp[idx_d][63:32] : mtimecmp[idx_d][31:0]) :
                                     (off[2] ? mtime_nxt[63:32] : mtime_nxt[31:0]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            busy      <= 1'b1;
            rdata     <= 32'd0;
            error     <= 1'b0;
            pcnt      <= '0;
            mtime     <= 64'd0;
            msip      <= '0;
            timer_int <= '0;
            op_wr     <= 1'b0;
            err_q     <= 1'b0;
            hi_q      <= 1'b0;
            kind_q    <= K_MSIP;
            idx_q     <= '0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
        end else begin
            pcnt  <= tick ? '0 : pcnt + PW'(1);
            mtime <= mtime_nxt;
            for (int h = 0; h < NUM_HARTS; h++) timer_int[h] <= mtime >= mtimecmp[h];
            if (wr_go && kind_q == K_MSIP && be_q[0]) msip[idx_q] <= wdata_q[0];
            if (wr_go && kind_q == K_CMP)
                mtimecmp[idx_q] <= hi_q ? {merge(mtimecmp[idx_q][63:32], wdata_q, be_q), mtimecmp[idx_q][31:0]}
                                        : {mtimecmp[idx_q][63:32], merge(mtimecmp[idx_q][31:0], wdata_q, be_q)};
            if (state == IDLE) begin
                if (ren || wen) begin
                    state   <= RESP;
                    busy    <= 1'b0;
                    error   <= dec_err;
                    rdata   <= (dec_err || wen) ? 32'd0 : rd_d;
                    op_wr   <= wen;
                    err_q   <= dec_err;
                    hi_q    <= off[2];
                    kind_q  <= kind_d;
                    idx_q   <= idx_d;
                    wdata_q <= wdata;
                    be_q    <= byte_en;
                end
            end else begin
                state <= IDLE;
                busy  <= 1'b1;
                error <= 1'b0;
                rdata <= 32'd0;
            end
        end
    end
endmodule
